num_accum: RTL

Downstream compute endpoint for the number-generator traffic: accepts AXI-Stream packets addressed to this node, buffers beats in a small FIFO, sums each packet's data words, and returns one result beat per packet on its AXI-Stream master toward a fixed reply destination. It sits on the NoC egress port that receives generator traffic (dest 2) and drives a NoC ingress port.

---
 rtl/num_accum.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/num_accum.sv
// -----------------------------------------------------------------------------
// num_accum
//   Compute endpoint for number-generator traffic. Beats addressed to MY_DEST
//   are buffered in a small FIFO, each packet's data words are summed
//   (mod 2^TDATAW), and one result beat per packet is returned toward
//   RET_DEST. Beats addressed elsewhere are consumed and counted as misroutes.
//
// Ports
//   CLK            in   sole clock, rising edge
//   RST_N          in   asynchronous active-low reset
//   AXIS_S_TVALID  in   slave valid
//   AXIS_S_TREADY  out  slave ready (run flag and FIFO not full)
//   AXIS_S_TDATA   in   operand word
//   AXIS_S_TLAST   in   last beat of packet
//   AXIS_S_TID     in   source ID
//   AXIS_S_TDEST   in   destination, compared to MY_DEST
//   AXIS_M_TVALID  out  result valid
//   AXIS_M_TREADY  in   result ready
//   AXIS_M_TDATA   out  packet sum
//   AXIS_M_TLAST   out  1 while TVALID
//   AXIS_M_TID     out  TID of the packet's last beat
//   AXIS_M_TDEST   out  RET_DEST
//   STAT_PKTS      out  results delivered, wraps
//   STAT_MISROUTE  out  dropped beats, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module num_accum #(
  parameter int                 TDATAW     = 32,
  parameter int                 TDESTW     = 4,
  parameter int                 TIDW       = 2,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [TDESTW-1:0]  MY_DEST    = 4'h2,
  parameter logic [TDESTW-1:0]  RET_DEST   = 4'h0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  output logic [15:0]       STAT_PKTS,
  output logic [15:0]       STAT_MISROUTE
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [TDATAW-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic [TIDW-1:0]   r_mem_id   [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_run;

  // Accumulator, FSM and result registers
  state_t            r_state;
  state_t            w_state_nxt;
  logic [TDATAW-1:0] r_sum;
  logic              r_m_tvalid;
  logic [TDATAW-1:0] r_m_tdata;
  logic              r_m_tlast;
  logic [TIDW-1:0]   r_m_tid;
  logic [TDESTW-1:0] r_m_tdest;
  logic [15:0]       r_stat_pkts;
  logic [15:0]       r_stat_mis;

  logic              w_s_tready;
  logic              w_s_hs;
  logic              w_push;
  logic              w_misroute;
  logic              w_pop;
  logic              w_load;
  logic              w_done;
  logic [TDATAW-1:0] w_head_data;
  logic              w_head_last;
  logic [TIDW-1:0]   w_head_id;
  logic [TDATAW-1:0] w_sum_nxt;

  // Ready depends only on registers, so no combinational path from S_TVALID.
  assign w_s_tready = r_run & (r_count != FULL_CNT);
  assign w_s_hs     = AXIS_S_TVALID & w_s_tready;
  assign w_push     = w_s_hs & (AXIS_S_TDEST == MY_DEST);
  assign w_misroute = w_s_hs & (AXIS_S_TDEST != MY_DEST);

  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_last = r_mem_last[r_rd_ptr];
  assign w_head_id   = r_mem_id[r_rd_ptr];
  assign w_sum_nxt   = r_sum + w_head_data;

  // NOTE: the storage array has no reset; r_count alone says which entries
  // are valid, so stale contents after reset are never read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= AXIS_S_TDATA;
      r_mem_last[r_wr_ptr] <= AXIS_S_TLAST;
      r_mem_id[r_wr_ptr]   <= AXIS_S_TID;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_run    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_ACC;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_ACC: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_last) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (r_m_tvalid && AXIS_M_TREADY) begin
          w_done      = 1'b1;
          w_state_nxt = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Accumulator, result beat and statistics
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sum       <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tlast   <= 1'b0;
      r_m_tid     <= '0;
      r_m_tdest   <= '0;
      r_stat_pkts <= '0;
      r_stat_mis  <= '0;
    end else begin
      // Closing beat restarts the sum for the next packet.
      if (w_pop) r_sum <= w_load ? '0 : w_sum_nxt;
      if (w_load) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_sum_nxt;
        r_m_tlast  <= 1'b1;
        r_m_tid    <= w_head_id;
        r_m_tdest  <= RET_DEST;
      end else if (w_done) begin
        r_m_tvalid  <= 1'b0;
        r_m_tlast   <= 1'b0;
        r_stat_pkts <= r_stat_pkts + 16'd1;
      end
      if (w_misroute && (r_stat_mis != 16'hFFFF)) r_stat_mis <= r_stat_mis + 16'd1;
    end
  end

  assign AXIS_S_TREADY = w_s_tready;
  assign AXIS_M_TVALID = r_m_tvalid;
  assign AXIS_M_TDATA  = r_m_tdata;
  assign AXIS_M_TLAST  = r_m_tlast;
  assign AXIS_M_TID    = r_m_tid;
  assign AXIS_M_TDEST  = r_m_tdest;
  assign STAT_PKTS     = r_stat_pkts;
  assign STAT_MISROUTE = r_stat_mis;

endmodule
